// File: rtl/servant_timer_seq_pkg.sv
// Shared definitions for the servant timer sequencer:
// FSM state encoding and synchronizer depth.
package servant_timer_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_ARM,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/servant_sync_edge.sv
// Multi-flop synchronizer with rising-edge detect for a slow-clock irq.
// o_level is the synced value, o_rise is high for one cycle per edge.
module servant_sync_edge
    import servant_timer_seq_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);

    logic [DEPTH-1:0] r_sync;
    logic             r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_d};
            r_prev <= r_sync[DEPTH-1];
        end
    end

    assign o_level = r_sync[DEPTH-1];
    assign o_rise  = r_sync[DEPTH-1] & ~r_prev;

endmodule

// File: rtl/servant_timer_sequencer.sv
// Programs the timer compare value, then counts irq periods and
// measures each one in i_clk cycles.
module servant_timer_sequencer
    import servant_timer_seq_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int EW      = 24,
    parameter int TIMEOUT = 2**20
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [WIDTH-1:0] i_period,
    input  logic [7:0]       i_count,
    input  logic             i_irq,
    output logic [31:0]      o_wb_dat,
    output logic             o_wb_we,
    output logic             o_wb_cyc,
    output logic             o_busy,
    output logic             o_tick,
    output logic             o_done,
    output logic             o_aborted,
    output logic             o_err,
    output logic [EW-1:0]    o_elapsed
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [EW-1:0] EL_MAX   = '1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t        r_state;
    logic [7:0]    r_rem;
    logic [EW-1:0] r_el;
    logic [TW-1:0] r_tmo;

    logic          w_level;
    logic          w_rise;
    logic [EW-1:0] w_el_inc;
    logic          w_tmo_hit;

    servant_sync_edge #(.DEPTH(SYNC_DEPTH)) u_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_irq),
        .o_level(w_level),
        .o_rise (w_rise)
    );

    assign w_el_inc  = (r_el == EL_MAX) ? r_el : r_el + 1'b1;
    assign w_tmo_hit = (r_tmo == TMO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_el      <= '0;
            r_tmo     <= '0;
            o_wb_dat  <= '0;
            o_wb_we   <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_busy    <= 1'b0;
            o_tick    <= 1'b0;
            o_done    <= 1'b0;
            o_aborted <= 1'b0;
            o_err     <= 1'b0;
            o_elapsed <= '0;
        end else begin
            o_wb_we   <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_tick    <= 1'b0;
            o_done    <= 1'b0;
            o_aborted <= 1'b0;
            if (r_state != S_IDLE && i_stop) begin
                r_state   <= S_IDLE;
                o_busy    <= 1'b0;
                o_aborted <= 1'b1;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        // o_done still high means o_busy is too
                        o_busy <= i_start && !o_done;
                        if (i_start && !o_done) begin
                            r_state  <= S_WRITE;
                            r_rem    <= i_count;
                            o_err    <= 1'b0;
                            o_wb_cyc <= 1'b1;
                            o_wb_we  <= 1'b1;
                            o_wb_dat <= 32'(i_period);
                        end
                    end
                    S_WRITE: begin
                        r_el    <= '0;
                        r_tmo   <= '0;
                        r_state <= S_ARM;
                    end
                    S_ARM: begin
                        r_el <= w_el_inc;
                        if (w_tmo_hit) begin
                            o_err   <= 1'b1;
                            o_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                            if (!w_level) r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (w_rise) begin
                            o_tick    <= 1'b1;
                            o_elapsed <= w_el_inc;
                            r_el      <= '0;
                            r_tmo     <= '0;
                            if (r_rem != 8'd0) begin
                                r_rem <= r_rem - 8'd1;
                                if (r_rem == 8'd1) r_state <= S_DONE;
                            end
                        end else if (w_tmo_hit) begin
                            o_err   <= 1'b1;
                            o_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                            r_el  <= w_el_inc;
                        end
                    end
                    S_DONE: begin
                        o_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servant_timer_sequencer.sv
// Directed bench for servant_timer_sequencer.
// Main instance uses TIMEOUT=64; a second instance uses EW=4.
module tb_servant_timer_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, start4, stop, irq;
    logic [15:0] period;
    logic [7:0]  count;

    logic [31:0] dat, dat4;
    logic        we, cyc, busy, tick, done, aborted, err;
    logic        we4, cyc4, busy4, tick4, done4, aborted4, err4;
    logic [23:0] el;
    logic [3:0]  el4;

    int n_assert = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    int n_tick   = 0;
    int n_done   = 0;
    int base_wr, base_tick, base_done;

    always #5 clk = ~clk;

    servant_timer_sequencer #(.WIDTH(16), .EW(24), .TIMEOUT(64)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
        .i_period(period), .i_count(count), .i_irq(irq),
        .o_wb_dat(dat), .o_wb_we(we), .o_wb_cyc(cyc), .o_busy(busy),
        .o_tick(tick), .o_done(done), .o_aborted(aborted),
        .o_err(err), .o_elapsed(el)
    );

    servant_timer_sequencer #(.WIDTH(16), .EW(4), .TIMEOUT(1024)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .i_stop(stop),
        .i_period(period), .i_count(count), .i_irq(irq),
        .o_wb_dat(dat4), .o_wb_we(we4), .o_wb_cyc(cyc4), .o_busy(busy4),
        .o_tick(tick4), .o_done(done4), .o_aborted(aborted4),
        .o_err(err4), .o_elapsed(el4)
    );

    always @(negedge clk) begin
        if (cyc && we) n_wr++;
        if (tick) n_tick++;
        if (done) n_done++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start4 = 1'b0; stop = 1'b0;
        irq = 1'b0; period = 16'd0; count = 8'd0;
        step(2);
        chk("rst_cyc", {31'd0, cyc}, 0);
        chk("rst_we", {31'd0, we}, 0);
        chk("rst_dat", dat, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_flags", {28'd0, tick, done, aborted, err}, 0);
        chk("rst_el", {8'd0, el}, 0);
        rst = 1'b0;
        step(1);

        // basic run: period 3, count 2, 40-cycle irq period
        base_wr = n_wr; base_tick = n_tick; base_done = n_done;
        period = 16'd3; count = 8'd2; start = 1'b1;
        step(1);
        chk("b_write", {29'd0, cyc, we, busy}, 3'b111);
        chk("b_dat", dat, 32'h0000_0003);
        start = 1'b0; period = 16'd7; count = 8'd9;
        step(1);
        chk("b_cyc_low", {31'd0, cyc}, 0);
        step(3);
        irq = 1'b1;
        step(2);
        chk("b_tick_early", {31'd0, tick}, 0);
        step(1);
        chk("b_tick1", {31'd0, tick}, 1);
        step(17);
        irq = 1'b0;
        step(20);
        irq = 1'b1;
        step(3);
        chk("b_tick2", {30'd0, tick, done}, 2'b10);
        chk("b_elapsed", {8'd0, el}, 40);
        step(1);
        chk("b_done", {29'd0, tick, done, busy}, 3'b011);
        step(1);
        chk("b_idle", {30'd0, done, busy}, 0);
        chk("b_nwr", n_wr - base_wr, 1);
        chk("b_ntick", n_tick - base_tick, 2);
        chk("b_ndone", n_done - base_done, 1);
        chk("b_dat_hold", dat, 32'h0000_0003);

        // stale irq: high at start, low after 10, high 30 later
        base_tick = n_tick;
        period = 16'd5; count = 8'd1; start = 1'b1;
        step(1);
        start = 1'b0;
        step(9);
        irq = 1'b0;
        chk("s_no_stale", n_tick - base_tick, 0);
        step(30);
        irq = 1'b1;
        chk("s_no_tick_low", n_tick - base_tick, 0);
        step(2);
        chk("s_tick_early", {31'd0, tick}, 0);
        step(1);
        chk("s_tick", {31'd0, tick}, 1);
        step(1);
        chk("s_done", {30'd0, done, busy}, 2'b11);
        step(1);
        chk("s_idle", {31'd0, busy}, 0);

        // continuous count=0, abort after 5th tick
        irq = 1'b0;
        step(5);
        base_tick = n_tick; base_done = n_done;
        period = 16'd20; count = 8'd0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        for (int k = 0; k < 5; k++) begin
            irq = 1'b1;
            step(3);
            chk("c_tick", {31'd0, tick}, 1);
            if (k == 4) break;
            step(7);
            irq = 1'b0;
            step(10);
        end
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("c_abort", {29'd0, aborted, busy, tick}, 3'b100);
        step(1);
        chk("c_abort_pulse", {31'd0, aborted}, 0);
        chk("c_ntick", n_tick - base_tick, 5);
        chk("c_ndone", n_done - base_done, 0);
        irq = 1'b0;
        step(10);

        // stop with edge; start while busy ignored
        base_wr = n_wr; base_tick = n_tick;
        count = 8'd0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        irq = 1'b1;
        step(2);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("x_stop_edge", {29'd0, tick, aborted, busy}, 3'b010);
        chk("x_ntick", n_tick - base_tick, 0);
        chk("x_nwr", n_wr - base_wr, 1);
        irq = 1'b0;
        step(5);

        // timeout with irq stuck low
        count = 8'd1; start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        chk("t_arm", {30'd0, err, busy}, 2'b01);
        step(63);
        chk("t_pre", {30'd0, err, busy}, 2'b01);
        step(1);
        chk("t_err", {30'd0, err, busy}, 2'b10);
        step(3);
        chk("t_sticky", {31'd0, err}, 1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t_clear", {30'd0, err, cyc}, 2'b01);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("t_abort", {31'd0, aborted}, 1);
        step(3);

        // EW=4 saturation with a 100-cycle period
        count = 8'd2; start4 = 1'b1;
        step(1);
        start4 = 1'b0;
        step(3);
        irq = 1'b1;
        step(50);
        irq = 1'b0;
        step(50);
        irq = 1'b1;
        step(3);
        chk("e_tick", {31'd0, tick4}, 1);
        chk("e_sat", {28'd0, el4}, 15);
        step(2);
        irq = 1'b0;
        step(5);

        // reset mid-operation
        base_wr = n_wr;
        count = 8'd0; period = 16'd9; start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        irq = 1'b1;
        step(3);
        chk("r_tick", {31'd0, tick}, 1);
        rst = 1'b1;
        step(1);
        chk("r_outs", {26'd0, cyc, we, busy, tick, aborted, err}, 0);
        chk("r_dat_el", dat | {8'd0, el}, 0);
        rst = 1'b0; irq = 1'b0;
        step(1);
        chk("r_nwr", n_wr - base_wr, 1);
        base_tick = n_tick;
        period = 16'h1234; count = 8'd1; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("r_restart", {29'd0, cyc, we, busy}, 3'b111);
        chk("r_dat", dat, 32'h0000_1234);
        step(4);
        irq = 1'b1;
        step(3);
        chk("r_tick2", {31'd0, tick}, 1);
        step(1);
        chk("r_done", {31'd0, done}, 1);
        chk("r_ntick", n_tick - base_tick, 1);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/servant_timer_sequencer.md
# servant_timer_sequencer

Wishbone-side initiator for the slow-clock timer peripheral: programs the compare value, waits for the timer interrupt, and counts a requested number of periods. Measures each period in `i_clk` cycles, so firmware or the SNN control path can run "wait N timer periods" without polling. Sits between the control logic and the timer's `i_wb_dat`/`i_wb_we`/`i_wb_cyc`/`o_irq` pins, entirely in the `i_clk` domain.

## Interface
- `WIDTH`, 16: timer compare width; write data is the `WIDTH`-bit value zero-extended to 32 bits.
- `EW`, 24: width of the elapsed-cycle counter and of `o_elapsed`.
- `TIMEOUT`, 2**20: `i_clk` cycles allowed in ARM or WAIT before an error.
- `i_clk`  in  1  system clock; the only clock of this block.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  start request; honoured only in IDLE.
- `i_stop`  in  1  abort request; honoured in any non-IDLE state.
- `i_period`  in  WIDTH  compare value to program.
- `i_count`  in  8  number of periods; 0 means run until `i_stop`.
- `i_irq`  in  1  timer interrupt; asynchronous to `i_clk`.
- `o_wb_dat`  out  32  write data to the timer.
- `o_wb_we`  out  1  write enable.
- `o_wb_cyc`  out  1  cycle strobe.
- `o_busy`  out  1  high in any state except IDLE.
- `o_tick`  out  1  1-cycle pulse per counted period.
- `o_done`  out  1  1-cycle pulse when `i_count` periods have completed.
- `o_aborted`  out  1  1-cycle pulse on a `i_stop` abort.
- `o_err`  out  1  sticky timeout flag; cleared by the next accepted start.
- `o_elapsed`  out  EW  `i_clk` cycles in the last period, saturating.

## Operation
- States:
  - IDLE → WRITE on `i_start`.
  - WRITE lasts exactly one cycle and drives `o_wb_cyc=1`, `o_wb_we=1`, `o_wb_dat={0,period}`; then → ARM.
  - ARM → WAIT once the synced irq is 0.
  - WAIT: each rising edge of the synced irq pulses `o_tick`. When the remaining count reaches 0 → DONE; otherwise stay in WAIT.
  - DONE pulses `o_done` and → IDLE.
- The timer has no ack. A write is a single `cyc&we` cycle, and `o_wb_cyc` is 0 outside WRITE.
- ARM exists because the timer's irq can still be high from a previous run. Edges are counted only after irq has been seen low.
- `i_period` and `i_count` are latched at start; later changes are ignored.
- `i_irq` passes through a 2-flop synchronizer plus a previous-value flop. Rising edge = `sync & ~prev`.
- Remaining counter: loaded with `i_count` at start and decremented at each tick. With `i_count`=0 it never decrements and DONE is never reached.
- Elapsed counter:
  - cleared in WRITE, then increments each cycle and saturates at 2**EW-1.
  - At each tick, `o_elapsed` takes the current value (counted cycles + 1) and the counter is cleared.
- Timeout counter:
  - cleared on entering ARM and on every tick.
  - On reaching TIMEOUT in ARM or WAIT: set `o_err`, → IDLE, no `o_done`.
- Simultaneous events:
  - `i_stop` together with an edge: stop wins, no tick, `o_aborted` pulses.
  - Tick together with timeout: tick wins.
  - `i_start` while busy is ignored.
- Reset (including mid-operation):
  - state IDLE; `o_wb_cyc`, `o_wb_we`, `o_tick`, `o_done`, `o_aborted`, `o_err` all 0.
  - `o_wb_dat` 0, `o_elapsed` 0, synchronizer flops 0.
  - No write is issued on the reset cycle.

## Timing
- Start at cycle T (IDLE) → WRITE at T+1 → ARM at T+2.
- `i_irq` rising at T0 → synced at T0+2 → `o_tick` registered at T0+3.
- `o_done` comes one cycle after the final `o_tick`. `o_busy` drops the cycle after `o_done`.
- Abort: `i_stop` at T → `o_aborted` and IDLE at T+1.
- All outputs are registered.

## Structure
- Shared package/include `servant_timer_seq_pkg`: state encodings (IDLE, WRITE, ARM, WAIT, DONE) and the synchronizer depth constant.
- One sub-module, `servant_sync_edge`: 2-flop synchronizer plus rising-edge detector, reusable for other slow-clock irqs.
- The top level holds the FSM and the remaining, elapsed and timeout counters.

## Test plan
- **Basic run:** period=3, count=2, bench irq model toggles at 40-cycle periods → exactly one `cyc&we` cycle with dat=0x0000_0003; 2 `o_tick`; `o_done` one cycle after the 2nd tick; `o_elapsed`=40.
- **Stale irq:** irq held high at start, low after 10 cycles, high 30 cycles later → no tick during the stale high; first tick 3 cycles after the new edge.
- **Continuous and abort:** count=0, irq every 20 cycles, `i_stop` after the 5th tick → 5 ticks, `o_aborted` pulse, no `o_done`, `o_busy`=0 next cycle.
- **Timeout:** TIMEOUT=64, irq stuck low → `o_err`=1 at cycle 64 after ARM entry, then IDLE; next start clears `o_err`.
- **Collisions:** stop and edge in the same cycle → no tick, aborted. `i_start` while busy → no second write. EW=4 with a 100-cycle period → `o_elapsed`=15.
- **Reset mid-operation:** `i_rst` in WAIT → all outputs 0 next cycle, no spurious write; a new start works normally.
